// File: rtl/mod_exp_ctrl.sv
// Modular-exponentiation sequencer, R = M^E mod N.
// Left-to-right square-and-multiply over an external A*B mod N unit.
module mod_exp_ctrl #(
    parameter int W  = 256,
    parameter int CW = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] M,
    input  logic [W-1:0] E,
    input  logic [W-1:0] N,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] R,
    output logic [W-1:0] mm_A,
    output logic [W-1:0] mm_B,
    output logic [W-1:0] mm_N,
    output logic         mm_enable,
    input  logic [W-1:0] mm_S,
    input  logic         mm_finish
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SCAN = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_NEXT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_SQR  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;

    logic [2:0]    state;
    logic [1:0]    op;
    logic [CW-1:0] idx;
    logic          gap;
    logic [W-1:0]  m_q;
    logic [W-1:0]  e_q;
    logic [W-1:0]  n_q;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  zero_exp;
    logic          e_bit;

    // x^0 mod 1 is 0, otherwise 1
    assign zero_exp = (n_q == W'(1)) ? '0 : W'(1);
    assign e_bit    = e_q[idx];

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign mm_enable = (state == S_REQ);
    assign mm_N      = n_q;

    // Operand select; driven only while a request is outstanding
    always_comb begin
        mm_A = '0;
        mm_B = '0;
        if (state == S_REQ) begin
            unique case (1'b1)
                (op == OP_LOAD): begin
                    mm_A = m_q;
                    mm_B = W'(1);
                end
                (op == OP_SQR): begin
                    mm_A = r_acc;
                    mm_B = r_acc;
                end
                default: begin
                    mm_A = r_acc;
                    mm_B = m_q;
                end
            endcase
        end
    end

    // Sequencer: bit scan, request/gap handshake, result latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op    <= OP_LOAD;
            idx   <= '0;
            gap   <= 1'b0;
            m_q   <= '0;
            e_q   <= '0;
            n_q   <= '0;
            r_acc <= '0;
            R     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        m_q   <= M;
                        e_q   <= E;
                        n_q   <= N;
                        idx   <= CW'(W - 1);
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (e_bit) begin
                        op    <= OP_LOAD;
                        state <= S_REQ;
                    end else if (idx == '0) begin
                        r_acc <= zero_exp;
                        R     <= zero_exp;
                        state <= S_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_REQ: begin
                    if (mm_finish) begin
                        r_acc <= mm_S;
                        gap   <= 1'b0;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap) begin
                        state <= S_NEXT;
                    end else begin
                        gap <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (op == OP_SQR && e_bit) begin
                        op    <= OP_MUL;
                        state <= S_REQ;
                    end else if (idx == '0) begin
                        R     <= r_acc;
                        state <= S_DONE;
                    end else begin
                        idx   <= idx - 1'b1;
                        op    <= OP_SQR;
                        state <= S_REQ;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural multiplier responder,
// job-sequence model and independent right-to-left exponent model.
module tb_mod_exp_ctrl;

    localparam int W  = 256;
    localparam int CW = 8;
    localparam int LIMIT = 60000;

    typedef logic [W-1:0] word_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  start;
    word_t M, E, N, R;
    word_t mm_A, mm_B, mm_N, mm_S;
    logic  busy, done, mm_enable, mm_finish;

    always #5 clk = ~clk;

    mod_exp_ctrl #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .M(M), .E(E), .N(N),
        .busy(busy), .done(done), .R(R),
        .mm_A(mm_A), .mm_B(mm_B), .mm_N(mm_N),
        .mm_enable(mm_enable), .mm_S(mm_S), .mm_finish(mm_finish)
    );

    int    nchk = 0;
    int    nerr = 0;
    word_t qa[$];
    word_t qb[$];
    int    exp_jobs;
    int    njobs;
    int    ndone;
    word_t exp_n;
    word_t exp_r;
    int    lat_lo = 5;
    int    lat_hi = 5;
    bit    spur_gap = 1'b0;
    bit    spur_req = 1'b0;

    task automatic chk(string name, word_t act, word_t exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic word_t mmul(word_t a, word_t b, word_t n);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        p = p % {{W{1'b0}}, n};
        return p[W-1:0];
    endfunction

    // Right-to-left exponentiation, independent of the DUT's bit order
    function automatic word_t ref_exp(word_t m, word_t e, word_t n);
        word_t res, base;
        res  = (n == W'(1)) ? '0 : W'(1);
        base = mmul(m, W'(1), n);
        for (int i = 0; i < W; i++) begin
            if (e[i]) res = mmul(res, base, n);
            base = mmul(base, base, n);
        end
        return res;
    endfunction

    function automatic word_t rnd();
        word_t r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expected operand pairs, in issue order
    task automatic build_jobs(word_t m, word_t e, word_t n);
        int    t;
        word_t acc;
        qa.delete();
        qb.delete();
        t = -1;
        for (int i = 0; i < W; i++) if (e[i]) t = i;
        if (t >= 0) begin
            qa.push_back(m);
            qb.push_back(W'(1));
            acc = mmul(m, W'(1), n);
            for (int i = t - 1; i >= 0; i--) begin
                qa.push_back(acc);
                qb.push_back(acc);
                acc = mmul(acc, acc, n);
                if (e[i]) begin
                    qa.push_back(acc);
                    qb.push_back(m);
                    acc = mmul(acc, m, n);
                end
            end
        end
        exp_jobs = qa.size();
    endtask

    // Multiplier responder
    initial begin
        int cnt;
        bit act;
        bit fin_prev;
        bit real_fin;
        mm_finish = 1'b0;
        mm_S      = '0;
        act       = 1'b0;
        fin_prev  = 1'b0;
        cnt       = 0;
        forever begin
            @(posedge clk);
            #1;
            real_fin  = 1'b0;
            mm_finish = 1'b0;
            if (rst) begin
                act = 1'b0;
            end else if (spur_req) begin
                mm_finish = 1'b1;
                mm_S      = '1;
                spur_req  = 1'b0;
            end else if (spur_gap && fin_prev) begin
                mm_finish = 1'b1;
                mm_S      = '1;
            end else if (act) begin
                if (!mm_enable) begin
                    act = 1'b0;
                end else begin
                    cnt--;
                    if (cnt == 0) begin
                        mm_finish = 1'b1;
                        mm_S      = mmul(mm_A, mm_B, mm_N);
                        act       = 1'b0;
                        real_fin  = 1'b1;
                    end
                end
            end else if (mm_enable) begin
                act = 1'b1;
                cnt = $urandom_range(lat_hi, lat_lo);
            end
            fin_prev = real_fin;
        end
    end

    // Per-cycle compare against the job model
    initial begin
        bit    en_prev;
        bit    had_job;
        int    low_cnt;
        word_t hold_a, hold_b;
        en_prev = 1'b0;
        had_job = 1'b0;
        low_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                en_prev = 1'b0;
                had_job = 1'b0;
                low_cnt = 0;
            end else begin
                if (mm_enable && !en_prev) begin
                    njobs++;
                    if (had_job)
                        chk("gap_ge2", word_t'(low_cnt >= 2), W'(1));
                    if (qa.size() == 0) begin
                        chk("job_extra", word_t'(njobs), word_t'(exp_jobs));
                    end else begin
                        chk("job_A", mm_A, qa[0]);
                        chk("job_B", mm_B, qb[0]);
                        void'(qa.pop_front());
                        void'(qb.pop_front());
                    end
                    hold_a  = mm_A;
                    hold_b  = mm_B;
                    had_job = 1'b1;
                end else if (mm_enable) begin
                    chk("A_stable", mm_A, hold_a);
                    chk("B_stable", mm_B, hold_b);
                end
                if (mm_enable) low_cnt = 0;
                else low_cnt++;
                if (busy) chk("mm_N", mm_N, exp_n);
                if (done) ndone++;
                en_prev = mm_enable;
            end
        end
    end

    task automatic launch(word_t m, word_t e, word_t n);
        build_jobs(m, e, n);
        exp_n = n;
        exp_r = ref_exp(m, e, n);
        njobs = 0;
        ndone = 0;
        @(posedge clk);
        #1;
        M     = m;
        E     = e;
        N     = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        M     = ~m;
        E     = ~e;
        N     = ~n;
    endtask

    task automatic wait_done(bit has_lit, word_t lit, int exp_k, bit poke);
        int k;
        bit ok;
        k  = 0;
        ok = 1'b0;
        while (1) begin
            @(negedge clk);
            k++;
            if (k == 1) chk("busy_after_start", word_t'(busy), W'(1));
            if (poke && k == 20) start = 1'b1;
            if (poke && k == 21) start = 1'b0;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (k > LIMIT) break;
        end
        if (!ok) begin
            chk("done_timeout", W'(0), W'(1));
        end else begin
            chk("R_model", R, exp_r);
            if (has_lit) chk("R_literal", R, lit);
            if (exp_k >= 0) chk("done_latency", word_t'(k), word_t'(exp_k));
            chk("job_count", word_t'(njobs), word_t'(exp_jobs));
            @(negedge clk);
            chk("done_pulse", word_t'(done), W'(0));
            chk("busy_drop", word_t'(busy), W'(0));
            chk("done_once", word_t'(ndone), W'(1));
            chk("R_hold", R, exp_r);
        end
    endtask

    task automatic run(word_t m, word_t e, word_t n,
                       bit has_lit, word_t lit, int exp_k, bit poke);
        launch(m, e, n);
        wait_done(has_lit, lit, exp_k, poke);
    endtask

    initial begin
        word_t rm, re, rn;
        int    w;
        rst   = 1'b1;
        start = 1'b0;
        M     = '0;
        E     = '0;
        N     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", word_t'(busy), W'(0));
        chk("rst_done", word_t'(done), W'(0));
        chk("rst_en", word_t'(mm_enable), W'(0));
        chk("rst_R", R, W'(0));
        rst = 1'b0;

        lat_lo = 5;
        lat_hi = 5;
        run(W'(4), W'(13), W'(497), 1'b1, W'(445), -1, 1'b0);
        chk("six_jobs", word_t'(njobs), W'(6));

        spur_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("spur_idle_busy", word_t'(busy), W'(0));
        chk("spur_idle_R", R, W'(445));

        run(W'(4), W'(0), W'(497), 1'b1, W'(1), W + 1, 1'b0);
        chk("e0_no_jobs", word_t'(njobs), W'(0));
        run(W'(123), W'(0), W'(1), 1'b1, W'(0), W + 1, 1'b0);

        run(W'(7), W'(1), W'(5), 1'b1, W'(2), -1, 1'b0);
        chk("load_only", word_t'(njobs), W'(1));

        spur_gap = 1'b1;
        run(W'(4), W'(13), W'(497), 1'b1, W'(445), -1, 1'b0);
        spur_gap = 1'b0;

        run(W'(4), W'(13), W'(497), 1'b1, W'(445), -1, 1'b1);
        chk("poke_jobs", word_t'(njobs), W'(6));

        lat_lo = 1;
        lat_hi = 300;
        rm = rnd();
        rn = rnd();
        rn[W-1] = 1'b1;
        re = '0;
        re[31:0] = $urandom;
        re[31] = 1'b1;
        run(rm, re, rn, 1'b0, '0, -1, 1'b0);

        lat_lo = 1;
        lat_hi = 4;
        rm = rnd();
        rn = rnd();
        re = rnd();
        rn[0] = 1'b1;
        run(rm, re, rn, 1'b0, '0, -1, 1'b0);

        lat_lo = 5;
        lat_hi = 5;
        launch(W'(4), W'(13), W'(497));
        w = 0;
        while (!(mm_enable && njobs >= 3) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("reach_req", word_t'(mm_enable), W'(1));
        rst = 1'b1;
        #1;
        chk("arst_busy", word_t'(busy), W'(0));
        chk("arst_done", word_t'(done), W'(0));
        chk("arst_en", word_t'(mm_enable), W'(0));
        chk("arst_A", mm_A, W'(0));
        chk("arst_B", mm_B, W'(0));
        chk("arst_N", mm_N, W'(0));
        chk("arst_R", R, W'(0));
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst = 1'b0;
        run(W'(4), W'(13), W'(497), 1'b1, W'(445), -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
